// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 master that shifts one FRAME_BYTES command out MSB-first and captures the reply
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake, cmd_data byte0 in the top byte, sent first
//   rsp_valid/rsp_data  one-cycle pulse with the MISO bytes of the frame just finished
//   busy                high from accept until the inter-frame gap has elapsed
//   spi_sck/mosi/miso   mode 0: MOSI changes on SCK fall, MISO sampled on SCK rise
//   spi_ss              active-low slave select
module spi_cmd_master #(
  parameter int CLK_DIV = 5,
  parameter int FRAME_BYTES = 6,
  parameter int SS_LEAD = 5,
  parameter int SS_TRAIL = 5,
  parameter int SS_GAP = 20,
  localparam int W = 8 * FRAME_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         busy,
  output logic         spi_sck,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_ss
);
  localparam int BW = $clog2(W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TM = SS_GAP > SS_LEAD ? (SS_GAP > SS_TRAIL ? SS_GAP : SS_TRAIL)
                                       : (SS_LEAD > SS_TRAIL ? SS_LEAD : SS_TRAIL);
  localparam int TW = $clog2(TM + 1);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  state_t state, nxt;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] div;
  logic [TW-1:0] tcnt;
  logic [W-2:0] tx;
  logic [W-1:0] rx;
  logic accept, div_done, rise, fall, last, t_done;
  always_comb begin
    accept = state == IDLE && cmd_valid && cmd_ready;
    div_done = div == DW'(CLK_DIV - 1);
    rise = state == SHIFT && div_done && !spi_sck;
    fall = state == SHIFT && div_done && spi_sck;
    last = fall && bcnt == BW'(W - 1);
    t_done = tcnt == TW'(state == LEAD ? SS_LEAD - 1 : state == TRAIL ? SS_TRAIL - 1 : SS_GAP - 1);
    nxt = state == IDLE  ? (accept ? LEAD : IDLE) :
          state == LEAD  ? (t_done ? SHIFT : LEAD) :
          state == SHIFT ? (last ? TRAIL : SHIFT) :
          state == TRAIL ? (t_done ? GAP : TRAIL) :
          t_done ? IDLE : GAP;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      busy <= 1'b0;
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
      spi_ss <= 1'b1;
      tx <= '0;
      rx <= '0;
      bcnt <= '0;
      div <= '0;
      tcnt <= '0;
    end else begin
      cmd_ready <= nxt == IDLE;
      busy <= nxt != IDLE;
      spi_ss <= !(nxt == LEAD || nxt == SHIFT || nxt == TRAIL);
      rsp_valid <= state == TRAIL && t_done;
      if (state == TRAIL && t_done) rsp_data <= rx;
      tcnt <= nxt == state && (state == LEAD || state == TRAIL || state == GAP) ? tcnt + 1'b1 : '0;
      div <= state != SHIFT || div_done ? '0 : div + 1'b1;
      spi_sck <= state == SHIFT && div_done ? !spi_sck : spi_sck;
      bcnt <= state != SHIFT ? '0 : fall ? bcnt + 1'b1 : bcnt;
      if (rise) rx <= {rx[W-2:0], spi_miso};
      // tx holds the bits still to be sent after the one currently on MOSI
      if (accept) begin
        tx <= cmd_data[W-2:0];
        spi_mosi <= cmd_data[W-1];
      end else if (last) begin
        spi_mosi <= 1'b0;
      end else if (fall) begin
        spi_mosi <= tx[W-2];
        tx <= {tx[W-3:0], 1'b0};
      end
    end
  end
endmodule
